mem_byte_sequencer: RTL and testbench
=====================================

Name: mem_byte_sequencer

Overview:
- Bridge between the MIPS core's data-access request and the byte-wide external memory port (8-bit address, 8-bit read/write, registered read data, 1-cycle write).
- Turns one word or byte load/store request into a sequence of byte accesses and assembles or splits the 32-bit data.
- Sits directly upstream of the external memory's data port; the instruction port is not touched.

Parameters:
- ADDR_W, 8, byte address width on both sides.
- BYTE_LANES, 4, bytes per word (fixed 4; parameter exists only for the counter width).

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-high reset
- req  input  1  access request; sampled only in IDLE
- we  input  1  1 = store, 0 = load; sampled with req
- size  input  1  1 = word, 0 = byte; sampled with req
- addr  input  ADDR_W  byte address; sampled with req
- wdata  input  32  store data; byte stores use wdata[7:0]
- rdata  output  32  load result; valid when done=1, held until next load completes
- done  output  1  1-cycle completion pulse
- err  output  1  qualifies done: misaligned word access
- busy  output  1  high whenever state != IDLE
- rw_addr  output  ADDR_W  byte address to memory
- w  output  8  write byte to memory
- r  input  8  read byte from memory; reflects rw_addr from the previous cycle
- w_en  output  1  memory byte write enable

Behaviour:
- Reset (async, active-high): state=IDLE, cnt=0, rdata=0, done=0, err=0, w_en=0, rw_addr=0, w=0. A reset during RD or WR aborts the access. Bytes already written stay in memory. No done is issued.
- States: IDLE, RD, WR, FIN.
- IDLE, on an edge with req=1:
  - Latch we, size, addr (base) and wdata; set cnt=0.
  - If size=1 and addr[1:0]!=0: go to FIN with err=1 and make no memory access.
  - Otherwise go to RD (we=0) or WR (we=1).
  - While busy, req is ignored; no queuing.
- Lane order is big-endian: byte offset 0 maps to bits [31:24] and offset 3 to [7:0]. A byte access uses lane 3, so the result is zero-extended into rdata[7:0].
- RD state:
  - rw_addr = base + min(cnt, N-1), where N=4 for a word and N=1 for a byte.
  - On each edge with cnt>=1, capture r into lane cnt-1 (byte: into rdata[7:0], upper bits cleared).
  - cnt increments each edge. When cnt reaches N, go to FIN.
  - A word takes 5 RD cycles; a byte takes 2. rdata is updated only at the final capture and stays stable otherwise.
- WR state:
  - rw_addr = base + cnt, w_en=1, w = latched lane cnt (byte: wdata[7:0]).
  - After N cycles, go to FIN.
  - A word takes 4 WR cycles; a byte takes 1.
- FIN state: done=1 for exactly one cycle (err as latched), then go to IDLE. busy falls in that same cycle.
- Latency from the req-accept edge to the done cycle: word load 6, byte load 3, word store 5, byte store 2, misaligned 1.
- w_en is 0 in every state except WR. rw_addr holds its last value in IDLE/FIN. w is don't-care when w_en=0 but is driven to 0.
- Address arithmetic is modulo 2^ADDR_W. Wrap-around is legal only for byte accesses; aligned words cannot cross the wrap.
- A req already high in the FIN cycle is not accepted until the following IDLE cycle, so there is at least one idle cycle between accesses.

Decomposition:
- Shared package: state encoding (IDLE/RD/WR/FIN), LANE_BITS=2, and the big-endian lane-to-bit-slice mapping function. The memory model and this block must use the same mapping.
- One natural sub-module: mem_byte_lane_mux (combinational lane select for w, plus lane insert for rdata capture). The counter and FSM stay in the top module.

Test Plan:
- Word load: memory word at byte addr 0x10 = 0xDEADBEEF; req, we=0, size=1, addr=0x10 -> rw_addr steps 0x10..0x13; done exactly 6 cycles after accept with rdata=0xDEADBEEF, err=0; w_en never asserted.
- Word store then reload: store 0x12345678 to 0x20 -> w_en high 4 cycles, w = 0x12,0x34,0x56,0x78 at 0x20..0x23, done at cycle 5. A word load of 0x20 then returns 0x12345678.
- Byte store/load: byte store wdata=0x000000A5 to 0x22 -> only 0x22 changes. Word at 0x20 reads 0x1234A578; byte load of 0x22 -> rdata=0x000000A5 after 3 cycles.
- Misaligned: word load at 0x21 -> done and err=1 one cycle after accept; w_en=0 and rw_addr unchanged throughout.
- Busy and back-to-back: hold req=1 continuously with alternating requests -> a second request is accepted only in the IDLE cycle after done; no request is lost or duplicated; busy matches state.
- Reset mid-store: assert reset asynchronously during the 3rd WR cycle of a 0xCAFEF00D store to 0x30 -> w_en drops immediately, no done. Memory holds 0xCA,0xFE at 0x30/0x31 and old data at 0x32/0x33; the next request completes normally.

Source files
------------

// File: rtl/mem_byte_sequencer_pkg.sv
// mem_byte_sequencer_pkg: shared state encoding and big-endian lane mapping
package mem_byte_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_e;
    localparam int LANE_BITS = 2;
    // Byte offset 0 sits in bits [31:24], offset 3 in bits [7:0]
    function automatic logic [4:0] lane_lsb(input logic [LANE_BITS-1:0] lane);
        return {~lane, 3'b000};
    endfunction
endpackage

// File: rtl/mem_byte_lane_mux.sv
// mem_byte_lane_mux: selects the store byte and inserts a read byte into a word
module mem_byte_lane_mux
    import mem_byte_sequencer_pkg::*;
(
    input  logic [31:0]          wdata,
    input  logic [LANE_BITS-1:0] w_lane,
    output logic [7:0]           w_byte,
    input  logic [31:0]          acc,
    input  logic [LANE_BITS-1:0] r_lane,
    input  logic [7:0]           r,
    output logic [31:0]          acc_ins
);
    // Pick the outgoing lane and overwrite the incoming lane of the accumulator
    always_comb begin
        w_byte = wdata[lane_lsb(w_lane) +: 8];
        acc_ins = acc;
        acc_ins[lane_lsb(r_lane) +: 8] = r;
    end
endmodule

// File: rtl/mem_byte_sequencer.sv
// mem_byte_sequencer: splits word/byte loads and stores into byte-wide memory accesses
module mem_byte_sequencer
    import mem_byte_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int BYTE_LANES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic              size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] rw_addr,
    output logic [7:0]        w,
    input  logic [7:0]        r,
    output logic              w_en
);
    localparam int CNT_W = $clog2(BYTE_LANES) + 1;
    localparam logic [CNT_W-1:0] WORD_N = CNT_W'(BYTE_LANES);

    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, n, last, off, r_idx;
    logic size_q, size_d, err_q, err_d;
    logic [ADDR_W-1:0] base_q, base_d, last_addr_q, last_addr_d;
    logic [31:0] wdata_q, wdata_d, acc_q, acc_d, rdata_q, rdata_d, acc_ins;
    logic [7:0] w_byte;
    logic [LANE_BITS-1:0] w_lane, r_lane;
    logic active;

    assign n = size_q ? WORD_N : CNT_W'(1);
    assign last = n - CNT_W'(1);
    assign off = (cnt_q > last) ? last : cnt_q;
    assign r_idx = cnt_q - CNT_W'(1);
    assign w_lane = size_q ? cnt_q[LANE_BITS-1:0] : '1;
    assign r_lane = size_q ? r_idx[LANE_BITS-1:0] : '1;
    assign active = (state_q == RD) || (state_q == WR);
    assign rw_addr = active ? base_q + ADDR_W'(off) : last_addr_q;
    assign last_addr_d = rw_addr;
    assign busy = state_q != IDLE;
    assign done = state_q == FIN;
    assign err = done && err_q;
    assign w_en = state_q == WR;
    assign w = w_en ? w_byte : 8'h00;
    assign rdata = rdata_q;

    mem_byte_lane_mux u_lane_mux (
        .wdata   (wdata_q),
        .w_lane  (w_lane),
        .w_byte  (w_byte),
        .acc     (size_q ? acc_q : 32'h0),
        .r_lane  (r_lane),
        .r       (r),
        .acc_ins (acc_ins)
    );

    // Next-state: accept in IDLE, step the byte counter in RD/WR, pulse done in FIN
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        size_d = size_q;
        err_d = err_q;
        base_d = base_q;
        wdata_d = wdata_q;
        acc_d = acc_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req) begin
                size_d = size;
                base_d = addr;
                wdata_d = wdata;
                cnt_d = '0;
                err_d = size && (addr[1:0] != 2'b00);
                state_d = err_d ? FIN : (we ? WR : RD);
            end
            RD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q != '0) acc_d = acc_ins;
                if (cnt_q == n) begin
                    rdata_d = acc_ins;
                    state_d = FIN;
                end
            end
            WR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == last) state_d = FIN;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            size_q <= 1'b0;
            err_q <= 1'b0;
            base_q <= '0;
            last_addr_q <= '0;
            wdata_q <= '0;
            acc_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            size_q <= size_d;
            err_q <= err_d;
            base_q <= base_d;
            last_addr_q <= last_addr_d;
            wdata_q <= wdata_d;
            acc_q <= acc_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_byte_sequencer.sv
// tb_mem_byte_sequencer: randomized check of the byte sequencer against a byte-array model
module tb_mem_byte_sequencer;
    logic clk = 1'b0, reset = 1'b1, req = 1'b0, we = 1'b0, size = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic done, err, busy, w_en;
    logic [7:0] rw_addr, w, r;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic load_en = 1'b0;
    logic [7:0] load_a = 8'h00, load_d = 8'h00;
    logic [31:0] last_rd = 32'h0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mem_byte_sequencer #(.ADDR_W(8), .BYTE_LANES(4)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy),
        .rw_addr(rw_addr), .w(w), .r(r), .w_en(w_en)
    );

    always @(posedge clk) begin
        if (load_en) mem[load_a] <= load_d;
        else if (w_en) mem[rw_addr] <= w;
        r <= mem[rw_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mem_check();
        int m = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) m++;
        check("mem_image", m, 0);
    endtask

    task automatic do_req(input logic w_e, input logic sz, input logic [7:0] a,
                          input logic [31:0] wd, input logic hold);
        logic misal;
        int n, exp_lat, nw, lat;
        logic [7:0] a0, wb;
        logic [31:0] exp_rd;
        misal = sz && (a[1:0] != 2'b00);
        n = sz ? 4 : 1;
        exp_lat = misal ? 1 : (w_e ? n + 1 : n + 2);
        exp_rd = last_rd;
        if (!w_e && !misal)
            exp_rd = sz ? {ref_mem[a], ref_mem[8'(a + 1)], ref_mem[8'(a + 2)], ref_mem[8'(a + 3)]}
                        : {24'h0, ref_mem[a]};
        a0 = rw_addr;
        req = 1'b1; we = w_e; size = sz; addr = a; wdata = wd;
        if (done) begin
            @(negedge clk);
            check("no_accept_in_fin", 32'(busy), 0);
        end
        @(negedge clk);
        if (!hold) req = 1'b0;
        nw = 0;
        for (lat = 1; lat <= 12; lat++) begin
            if (w_en) begin
                wb = sz ? wd[31 - 8 * nw -: 8] : wd[7:0];
                check("wr_addr", 32'(rw_addr), 32'(8'(a + nw)));
                check("wr_byte", 32'(w), 32'(wb));
                nw++;
            end
            if (!w_e && !misal && !done)
                check("rd_addr", 32'(rw_addr), 32'(8'(a + ((lat - 1 < n - 1) ? lat - 1 : n - 1))));
            if (misal) check("misal_addr", 32'(rw_addr), 32'(a0));
            if (done) break;
            check("busy", 32'(busy), 1);
            if (hold) begin
                addr = 8'($urandom); wdata = $urandom; we = 1'($urandom); size = 1'($urandom);
            end
            @(negedge clk);
        end
        check("latency", lat, exp_lat);
        check("done", 32'(done), 1);
        check("err", 32'(err), 32'(misal));
        check("rdata", rdata, exp_rd);
        check("write_count", nw, (w_e && !misal) ? n : 0);
        if (w_e && !misal)
            for (int k = 0; k < n; k++) ref_mem[8'(a + k)] = sz ? wd[31 - 8 * k -: 8] : wd[7:0];
        last_rd = exp_rd;
    endtask

    initial begin
        logic rs;
        logic [7:0] ra;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        ref_mem[8'h10] = 8'hDE; ref_mem[8'h11] = 8'hAD; ref_mem[8'h12] = 8'hBE; ref_mem[8'h13] = 8'hEF;
        load_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            load_a = 8'(i); load_d = ref_mem[i];
        end
        @(negedge clk);
        load_en = 1'b0;
        check("rst_rdata", rdata, 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_w_en", 32'(w_en), 0);
        check("rst_rw_addr", 32'(rw_addr), 0);
        check("rst_w", 32'(w), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        @(negedge clk);
        mem_check();

        do_req(1'b0, 1'b1, 8'h10, 32'h0, 1'b0);
        check("word_load", rdata, 32'hDEADBEEF);
        do_req(1'b1, 1'b1, 8'h20, 32'h12345678, 1'b0);
        do_req(1'b0, 1'b1, 8'h20, 32'h0, 1'b0);
        check("store_reload", rdata, 32'h12345678);
        do_req(1'b1, 1'b0, 8'h22, 32'h000000A5, 1'b0);
        do_req(1'b0, 1'b1, 8'h20, 32'h0, 1'b0);
        check("byte_merge", rdata, 32'h1234A578);
        do_req(1'b0, 1'b0, 8'h22, 32'h0, 1'b0);
        check("byte_load", rdata, 32'h000000A5);
        do_req(1'b0, 1'b1, 8'h21, 32'h0, 1'b0);
        check("misal_err", 32'(err), 1);

        do_req(1'b1, 1'b1, 8'h40, 32'hA1B2C3D4, 1'b1);
        do_req(1'b0, 1'b1, 8'h40, 32'h0, 1'b1);
        do_req(1'b1, 1'b0, 8'hFF, 32'h0000005A, 1'b1);
        do_req(1'b0, 1'b0, 8'hFF, 32'h0, 1'b1);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mem_check();

        we = 1'b1; size = 1'b1; addr = 8'h30; wdata = 32'hCAFEF00D; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_w_en", 32'(w_en), 1);
        check("mid_addr", 32'(rw_addr), 32'h32);
        #1 reset = 1'b1;
        #1;
        check("abort_w_en", 32'(w_en), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_rdata", rdata, 0);
        ref_mem[8'h30] = 8'hCA;
        ref_mem[8'h31] = 8'hFE;
        last_rd = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_no_done", 32'(done), 0);
        mem_check();
        do_req(1'b0, 1'b1, 8'h30, 32'h0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            rs = 1'($urandom);
            ra = 8'($urandom);
            if (rs && $urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            do_req(1'($urandom), rs, ra, $urandom, 1'($urandom));
        end
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mem_check();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
